// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin time-slice arbiter:
//   - default parameter values (requester count, slice field width)
//   - FSM state encoding (ST_IDLE / ST_GRANT)
//   - inc_mod(): wrap-around increment that also works for non-power-of-2 N
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_SLICE_W = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // (value + 1) mod modulus, for value in [0, modulus-1].
    function automatic int inc_mod(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational rotating priority pick: returns the first requester
// with req set, scanning ptr, ptr+1, ... and wrapping modulo N.
// Implemented as a double-width masked priority encoder: {req, req} is masked
// to the window [ptr, ptr+N), and the lowest set bit of that window wins.
//
// Ports:
//   req    in   N      request vector
//   ptr    in   ID_W   highest-priority index
//   found  out  1      some request is set
//   idx    out  ID_W   index of the chosen requester (0 when found=0)
// -----------------------------------------------------------------------------
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_masked;

    assign req_dbl = {req, req};

    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // so no path through the block can leave it unassigned (no latch).
        req_masked = '0;
        found      = 1'b0;
        idx        = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (i >= int'(ptr) && i < int'(ptr) + N) begin
                req_masked[i] = req_dbl[i];
            end
        end
        // Scan downward so the lowest set bit of the window is the last
        // assignment and therefore the winner.
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                found = 1'b1;
                idx   = ID_W'((i >= N) ? i - N : i);
            end
        end
    end

endmodule

// File: rtl/round_robin_timeslice_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_timeslice_arbiter
// Round-robin arbiter for N requesters. A grant is held for the owner's
// programmable slice (slice_len field, 0 treated as 1) and released early when
// the owner drops its request. Handover happens in the same edge as release,
// so there is never an idle cycle between consecutive owners.
//
// Ports:
//   clk         in   1          clock, all logic on posedge
//   rst         in   1          synchronous active-high reset
//   req         in   N          level-sensitive request vector
//   slice_len   in   N*SLICE_W  per-channel quantum, field i at [i*SLICE_W +: SLICE_W]
//   gnt         out  N          registered one-hot grant or all-zero
//   gnt_id      out  ID_W       index of current owner (valid with gnt_valid)
//   gnt_valid   out  1          some grant bit is set
//   slice_last  out  1          final cycle of a full-length slice
// -----------------------------------------------------------------------------
module round_robin_timeslice_arbiter
    import arb_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int SLICE_W = DEF_SLICE_W,
    parameter int ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*SLICE_W-1:0] slice_len,
    output logic [N-1:0]         gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 gnt_valid,
    output logic                 slice_last
);

    logic [0:0]         state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [SLICE_W-1:0] cnt_q,   cnt_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    logic [N-1:0]       gnt_q,   gnt_d;

    logic [SLICE_W-1:0] slice_field [N];
    logic [ID_W-1:0]    owner_next;
    logic [ID_W-1:0]    pick_ptr;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [N-1:0]       pick_onehot;
    logic [SLICE_W-1:0] pick_len;
    logic               release_now;

    for (genvar g = 0; g < N; g++) begin : g_field
        assign slice_field[g] = slice_len[g*SLICE_W +: SLICE_W];
    end

    assign owner_next = ID_W'(inc_mod(int'(owner_q), N));

    // While a grant is held, the only time the pick result is used is on
    // release, where priority starts just past the current owner. In IDLE
    // the stored pointer is used.
    assign pick_ptr = (state_q == ST_GRANT) ? owner_next : ptr_q;

    rr_priority_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Quantum for a grant being loaded now; a zero field means one cycle.
    assign pick_len = (slice_field[pick_idx] == '0) ? SLICE_W'(1) : slice_field[pick_idx];

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    assign release_now = (state_q == ST_GRANT) &&
                         (!req[owner_q] || (cnt_q == SLICE_W'(1)));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = ST_GRANT;
                owner_d = pick_idx;
                cnt_d   = pick_len;
                gnt_d   = pick_onehot;
            end
        end else if (release_now) begin
            ptr_d = owner_next;
            if (pick_found) begin
                // Back-to-back handover (possibly to the same owner when it is
                // the sole requester at expiry).
                owner_d = pick_idx;
                cnt_d   = pick_len;
                gnt_d   = pick_onehot;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q - SLICE_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_id     = owner_q;
    assign gnt_valid  = |gnt_q;
    assign slice_last = (state_q == ST_GRANT) && (cnt_q == SLICE_W'(1));

endmodule

// File: tb/tb_round_robin_timeslice_arbiter.sv
// -----------------------------------------------------------------------------
// tb_round_robin_timeslice_arbiter
// Directed scenarios with literal expectations, followed by randomized traffic.
// A behavioural model (owner / cycles-used / rotating pointer) predicts the
// outputs and is compared with the DUT on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_round_robin_timeslice_arbiter;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*SW-1:0] slice_len = '0;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            gnt_valid;
    logic            slice_last;

    int errors   = 0;
    int checks   = 0;
    bit check_en = 1'b0;

    // Behavioural model state: owner (-1 = none), cycles already spent in the
    // current slice, quantum of the current slice, and the priority pointer.
    int m_owner = -1;
    int m_used  = 0;
    int m_len   = 1;
    int m_ptr   = 0;

    logic [N-1:0] rot_seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [N-1:0] zero_seq [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0100};

    round_robin_timeslice_arbiter #(
        .N       (N),
        .SLICE_W (SW),
        .ID_W    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .slice_len  (slice_len),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid),
        .slice_last (slice_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int quantum(input logic [N*SW-1:0] s, input int i);
        logic [N*SW-1:0] sh;
        int f;
        sh = s >> (i * SW);
        f  = int'(sh[SW-1:0]);
        return (f == 0) ? 1 : f;
    endfunction

    // Model update, evaluated with the inputs present at the rising edge.
    always @(posedge clk) begin
        int p;
        if (rst) begin
            m_owner = -1;
            m_used  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            p = model_pick(req, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_used  = 0;
                m_len   = quantum(slice_len, p);
            end
        end else if (!req[m_owner] || (m_used + 1 == m_len)) begin
            m_ptr = (m_owner + 1) % N;
            p = model_pick(req, m_ptr);
            if (p >= 0) begin
                m_owner = p;
                m_used  = 0;
                m_len   = quantum(slice_len, p);
            end else begin
                m_owner = -1;
            end
        end else begin
            m_used++;
        end
    end

    // Compare process: DUT outputs against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        if (check_en) begin
            exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            check("model_gnt", 32'(gnt), 32'(exp_gnt));
            check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("model_slice_last", 32'(slice_last),
                  32'((m_owner >= 0) && (m_used + 1 == m_len)));
            if (m_owner >= 0) check("model_gnt_id", 32'(gnt_id), 32'(m_owner));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(1);
        rst = 1'b0;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_valid", 32'(gnt_valid), 32'h0);
    endtask

    initial begin
        // Full rotation, slices of 2.
        tick(1);
        check_en = 1'b1;
        tick(1);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_slice_last", 32'(slice_last), 32'h0);
        rst = 1'b0;
        req = 4'b1111;
        slice_len = 16'h2222;
        tick(1);
        for (int i = 0; i < 9; i++) begin
            check("rot_gnt", 32'(gnt), 32'(rot_seq[i]));
            check("rot_slice_last", 32'(slice_last), 32'(i % 2 == 1));
            tick(1);
        end

        // Early release, then pointer check.
        do_reset();
        req = 4'b0011;
        slice_len = 16'h0035;
        tick(1);
        check("early_first", 32'(gnt), 32'b0001);
        tick(1);
        check("early_second", 32'(gnt), 32'b0001);
        req = 4'b0010;
        tick(1);
        check("early_move", 32'(gnt), 32'b0010);
        req = 4'b0011;
        tick(1);
        check("ptr_hold1", 32'(gnt), 32'b0010);
        tick(1);
        check("ptr_hold2", 32'(gnt), 32'b0010);
        tick(1);
        check("ptr_back0", 32'(gnt), 32'b0001);

        // Sole requester re-grant.
        do_reset();
        req = 4'b0100;
        slice_len = 16'h0300;
        tick(1);
        check("pin_model_owner", 32'(m_owner), 32'd2);
        for (int c = 1; c <= 10; c++) begin
            check("sole_gnt", 32'(gnt), 32'b0100);
            check("sole_slice_last", 32'(slice_last), 32'(c % 3 == 0));
            tick(1);
        end

        // Skip and wrap.
        do_reset();
        req = 4'b0001;
        slice_len = 16'h1111;
        tick(1);
        check("wrap_g0", 32'(gnt), 32'b0001);
        req = 4'b1010;
        tick(1);
        check("wrap_gnt_a", 32'(gnt), 32'b0010);
        check("wrap_id_a", 32'(gnt_id), 32'd1);
        tick(1);
        check("wrap_gnt_b", 32'(gnt), 32'b1000);
        check("wrap_id_b", 32'(gnt_id), 32'd3);
        tick(1);
        check("wrap_gnt_c", 32'(gnt), 32'b0010);
        check("wrap_id_c", 32'(gnt_id), 32'd1);

        // Zero slices rotate every cycle; slice1 change applies next grant only.
        do_reset();
        req = 4'b1111;
        slice_len = 16'h0000;
        tick(1);
        check("zero_g0", 32'(gnt), 32'b0001);
        tick(1);
        check("zero_g1", 32'(gnt), 32'b0010);
        slice_len = 16'h0040;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("zero_seq", 32'(gnt), 32'(zero_seq[i]));
        end

        // Reset in the middle of a slice.
        do_reset();
        req = 4'b0100;
        slice_len = 16'h4444;
        tick(1);
        check("mid_g2", 32'(gnt), 32'b0100);
        tick(1);
        rst = 1'b1;
        req = 4'b1111;
        tick(1);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_valid", 32'(gnt_valid), 32'h0);
        rst = 1'b0;
        tick(1);
        check("mid_first", 32'(gnt), 32'b0001);

        // Randomized traffic, checked by the compare process every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 15) == 0) slice_len = (N*SW)'($urandom);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
